cnn_win_gen: RTL and testbench
==============================

Name: cnn_win_gen

Overview:
- Streaming 3x3 window generator for one binary IMG_W x IMG_H frame.
- Sits between the UART byte-to-bit unpacker, upstream, and cnn_core, downstream.
- Accepts one pixel bit per handshake in raster order, holds two line buffers, and emits every valid 3x3 neighbourhood as a 9-bit word.
- Output is row-major, ready/valid handshaked, and replaces the RAM re-read address sequencer.

Parameters:
- IMG_W, 28, pixels per row (>=3).
- IMG_H, 28, rows per frame (>=3).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- clr, input, 1, synchronous frame restart, pulsed when a result is transmitted.
- pix_in, input, 1, pixel bit.
- pix_vld, input, 1, pix_in valid.
- pix_rdy, output, 1, block can accept a pixel.
- win, output, 9, window bits; bit0 = top-left, bit2 = top-right, bit6 = bottom-left, bit8 = bottom-right.
- win_vld, output, 1, win valid.
- win_rdy, input, 1, consumer accepts win (cnn_core drives !bsy).
- frame_done, output, 1, one-cycle pulse after the last window is accepted.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-high (rst), per the already-decided interface.
- Reset values:
  - win = 0, win_vld = 0, frame_done = 0.
  - col = 0, row = 0, state = FILL.
  - pix_rdy = 1 after reset.
  - Line-buffer and shift-register contents are don't-care and are not reset.
- Pixel accept: accept = pix_vld & pix_rdy.
- pix_rdy is combinational: (state != DONE) & (!win_vld | win_rdy).
- On accept at position (row, col):
  - Window shift registers shift left one column. The new right column is top = lb1[col], mid = lb0[col], bot = pix_in.
  - Then lb1[col] <= lb0[col] and lb0[col] <= pix_in.
  - col increments, wrapping IMG_W-1 -> 0. On wrap, row increments.
- Window emit:
  - If the accept has row >= 2 and col >= 2, then on the next clock win = the new 3x3 contents and win_vld = 1.
  - Latency is one cycle from accept to win_vld.
  - win_vld and win are held stable until win_vld & win_rdy.
  - A handshake with no new emit clears win_vld.
  - A handshake with a simultaneous emit loads the new window and keeps win_vld high.
- Emit count: (IMG_W-2)*(IMG_H-2) windows per frame (676 at the defaults), in raster order of the top-left corner.
- State machine:
  - FILL: row < 2. Moves to RUN when accepting pixel (1, IMG_W-1).
  - RUN: emitting windows. Moves to DRAIN when accepting pixel (IMG_H-1, IMG_W-1); col and row then wrap to 0.
  - DRAIN: last window pending. Moves to DONE on its handshake, and frame_done pulses that same clock edge.
  - DONE: pix_rdy = 0, and extra pixels are ignored. Stays in DONE until clr.
- clr:
  - Highest priority after rst, and wins over a simultaneous accept or handshake.
  - Sets col = row = 0, win_vld = 0, frame_done = 0, state = FILL.
  - Line buffers are not cleared; rows 0-1 overwrite them before any use.
- Reset mid-frame: all state returns to reset values immediately, and no window or frame_done is emitted.
- pix_in is ignored whenever pix_vld = 0.

Optional Feature:
- Macro: CNN_WIN_CNT_EN.
- Defined: adds output win_cnt[9:0].
  - Counts windows handshaken in the current frame and increments on win_vld & win_rdy.
  - Reset value 0. Cleared by clr. Reads 676 in DONE at the defaults.
  - Saturates at 10'h3FF.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- All-ones frame, pix_vld held 1, win_rdy held 1: exactly 676 windows, all 9'h1FF; first win_vld 1 cycle after accepting pixel (2,2); single frame_done pulse.
- Checkerboard pix = (row+col)&1, win_rdy = 1: first window 9'h0AA, second 9'h155, alternating along each row; each output row starts with the opposite value of the previous one.
- Single 1 at (5,7), rest 0: exactly 9 nonzero windows.
  - Top-left (5,7) gives 9'h001.
  - Top-left (3,5) gives 9'h100.
  - Top-left (4,6) gives 9'h010.
- Backpressure: win_rdy = 0 for 10 cycles while pixels are offered: pix_rdy = 0, win and win_vld are stable, and no pixel is lost; the full frame still yields the 676 all-ones windows.
- clr asserted at pixel 300 in the same cycle as a handshake: next cycle win_vld = 0 and state = FILL; a fresh all-ones frame yields 676 windows.
- rst pulsed mid-frame, then a full frame: outputs return to 0 during reset and the frame is handled as first. With CNN_WIN_CNT_EN, win_cnt = 0 after rst and win_cnt = 676 in DONE.

Source files
------------

// File: rtl/cnn_win_gen.sv
// rtl/cnn_win_gen.sv - streaming 3x3 window generator over two line buffers; define CNN_WIN_CNT_EN to add the win_cnt output
module cnn_win_gen #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       pix_in,
    input  logic       pix_vld,
    output logic       pix_rdy,
    output logic [8:0] win,
    output logic       win_vld,
    input  logic       win_rdy,
`ifdef CNN_WIN_CNT_EN
    output logic [9:0] win_cnt,
`endif
    output logic       frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {FILL, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [8:0]       win_q, win_d;
    logic             win_vld_q, win_vld_d;
    logic             frame_done_q, frame_done_d;
    logic [IMG_W-1:0] lb0_q, lb0_d;
    logic [IMG_W-1:0] lb1_q, lb1_d;
    logic [8:0]       sr_q, sr_d;
    logic             hs, acc, emit, last_col, last_row;

    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);
    // clr swallows a coincident pixel so a restarted frame never sees it
    assign acc      = pix_vld & pix_rdy & ~clr;
    assign emit     = acc & (row_q >= RW'(2)) & (col_q >= CW'(2));

    // FSM outputs: accept readiness and the window handshake
    always_comb begin
        pix_rdy = (state_q != DONE) & (~win_vld_q | win_rdy);
        hs      = win_vld_q & win_rdy;
    end

    // FSM next state: FILL until two rows are buffered, RUN to the last pixel, DRAIN until the last window leaves
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL:    if (acc && row_q == RW'(1) && last_col) state_d = RUN;
                RUN:     if (acc && last_row && last_col) state_d = DRAIN;
                DRAIN:   if (hs) state_d = DONE;
                default: state_d = DONE;
            endcase
        end
    end

    // Line buffers and window shift register: new right column is {lb1[col], lb0[col], pix_in}
    always_comb begin
        lb0_d = lb0_q;
        lb1_d = lb1_q;
        sr_d  = sr_q;
        if (acc) begin
            sr_d = {pix_in, sr_q[8:7], lb0_q[col_q], sr_q[5:4], lb1_q[col_q], sr_q[2:1]};
            lb1_d[col_q] = lb0_q[col_q];
            lb0_d[col_q] = pix_in;
        end
    end

    // Raster position, output window register and frame_done pulse
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_vld_d    = win_vld_q;
        frame_done_d = 1'b0;
        if (clr) begin
            col_d     = '0;
            row_d     = '0;
            win_vld_d = 1'b0;
        end else begin
            if (acc) begin
                if (last_col) begin
                    col_d = '0;
                    row_d = last_row ? '0 : row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            if (emit) begin
                win_d     = sr_d;
                win_vld_d = 1'b1;
            end else if (hs) begin
                win_vld_d = 1'b0;
            end
            frame_done_d = (state_q == DRAIN) & hs;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_vld_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_vld_q    <= win_vld_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Pixel storage carries no reset; rows 0-1 overwrite it before any window uses it
    always_ff @(posedge clk) begin
        lb0_q <= lb0_d;
        lb1_q <= lb1_d;
        sr_q  <= sr_d;
    end

    assign win        = win_q;
    assign win_vld    = win_vld_q;
    assign frame_done = frame_done_q;

`ifdef CNN_WIN_CNT_EN
    logic [9:0] win_cnt_q, win_cnt_d;

    // Saturating count of windows handed off in this frame
    always_comb begin
        win_cnt_d = win_cnt_q;
        if (clr) win_cnt_d = '0;
        else if (hs && win_cnt_q != 10'h3FF) win_cnt_d = win_cnt_q + 10'd1;
    end

    // Window counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) win_cnt_q <= '0;
        else     win_cnt_q <= win_cnt_d;
    end

    assign win_cnt = win_cnt_q;
`endif
endmodule

// File: tb/tb_cnn_win_gen.sv
// tb/tb_cnn_win_gen.sv - randomized self-checking bench for cnn_win_gen against a frame-level window model
module tb_cnn_win_gen;
    localparam int W    = 28;
    localparam int H    = 28;
    localparam int NWIN = (W - 2) * (H - 2);
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       rst, clr, pix_in, pix_vld, pix_rdy, win_vld, win_rdy, frame_done;
    logic [8:0] win;
`ifdef CNN_WIN_CNT_EN
    logic [9:0] win_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cnn_win_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .pix_in     (pix_in),
        .pix_vld    (pix_vld),
        .pix_rdy    (pix_rdy),
        .win        (win),
        .win_vld    (win_vld),
        .win_rdy    (win_rdy),
`ifdef CNN_WIN_CNT_EN
        .win_cnt    (win_cnt),
`endif
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // mode: 0 all ones, 1 checkerboard, 2 single one at (5,7), 3 random
    // abort_kind: 0 none, 1 clr at pixel abort_at, 2 rst at pixel abort_at
    task automatic run_frame(input int mode, input int vld_pct, input int rdy_pct, input bit pre_clr,
                             input int bp_at, input int abort_kind, input int abort_at);
        logic       img [H][W];
        logic [8:0] expq[$];
        logic [8:0] got[$];
        logic [8:0] w;
        logic [8:0] prev_win;
        int         pi, bp_left, nz;
        bit         bp_done, done_seen, exp_fd, exp_vld, stall, acc, hs, emit;

        pi = 0; bp_left = 0; nz = 0;
        bp_done = 0; done_seen = 0; exp_fd = 0; exp_vld = 0; stall = 0;
        prev_win = '0;

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (mode)
                    0:       img[r][c] = 1'b1;
                    1:       img[r][c] = 1'((r + c) & 1);
                    2:       img[r][c] = (r == 5 && c == 7);
                    default: img[r][c] = 1'($urandom_range(1));
                endcase
        for (int r = 0; r <= H - 3; r++)
            for (int c = 0; c <= W - 3; c++) begin
                w = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        w[i*3+j] = img[r+i][c+j];
                expq.push_back(w);
            end

        if (pre_clr) begin
            @(negedge clk); clr = 1'b1;
            @(negedge clk); clr = 1'b0;
        end

        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            chk("frame_done", frame_done, exp_fd);
            chk("win_vld", win_vld, exp_vld);
            if (stall) chk("win_hold", win, prev_win);
            if (frame_done) begin
                done_seen = 1;
                break;
            end
            if (bp_at >= 0 && !bp_done && pi == bp_at && win_vld) begin
                bp_left = 10;
                bp_done = 1;
            end
            pix_vld = (pi < NPIX) && ($urandom_range(99) < vld_pct);
            pix_in  = pix_vld ? img[pi / W][pi % W] : 1'($urandom_range(1));
            win_rdy = (bp_left > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
            if (abort_kind == 1 && pi == abort_at) clr = 1'b1;
            if (abort_kind == 2 && pi == abort_at) rst = 1'b1;
            #1;
            if (abort_kind == 1 && pi == abort_at) begin
                chk("clr_with_hs", win_vld & win_rdy, 1);
                @(negedge clk);
                clr = 1'b0; pix_vld = 1'b0; win_rdy = 1'b0;
                chk("clr_win_vld", win_vld, 0);
                chk("clr_frame_done", frame_done, 0);
                chk("clr_pix_rdy", pix_rdy, 1);
                return;
            end
            if (abort_kind == 2 && pi == abort_at) begin
                chk("rst_win", win, 0);
                chk("rst_win_vld", win_vld, 0);
                chk("rst_frame_done", frame_done, 0);
                chk("rst_pix_rdy", pix_rdy, 1);
`ifdef CNN_WIN_CNT_EN
                chk("rst_win_cnt", win_cnt, 0);
`endif
                @(negedge clk);
                rst = 1'b0; pix_vld = 1'b0; win_rdy = 1'b0;
                return;
            end
            acc = pix_vld & pix_rdy;
            hs  = win_vld & win_rdy;
            if (pi < NPIX) chk("pix_rdy", pix_rdy, !win_vld || win_rdy);
            if (bp_left > 0 && win_vld) chk("bp_pix_rdy", pix_rdy, 0);
            exp_fd = 0;
            emit   = 0;
            if (hs) begin
                if (expq.size() == 0) chk("extra_win", 1, 0);
                else begin
                    chk("win", win, expq[0]);
                    got.push_back(win);
                    void'(expq.pop_front());
                    exp_fd = (expq.size() == 0);
                end
            end
            if (acc) begin
                emit = (pi / W >= 2) && (pi % W >= 2);
                pi++;
            end
            exp_vld  = emit ? 1'b1 : (hs ? 1'b0 : exp_vld);
            stall    = win_vld & !win_rdy;
            prev_win = win;
            if (bp_left > 0) bp_left--;
        end

        if (!done_seen) chk("timeout", 0, 1);
        chk("win_count", got.size(), NWIN);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pix_vld = 1'b1; pix_in = 1'($urandom_range(1)); win_rdy = 1'b1;
            #1;
            chk("done_pix_rdy", pix_rdy, 0);
            chk("done_frame_done", frame_done, 0);
            chk("done_win_vld", win_vld, 0);
        end
        pix_vld = 1'b0;
`ifdef CNN_WIN_CNT_EN
        chk("win_cnt_done", win_cnt, NWIN);
`endif
        if (got.size() == NWIN) begin
            if (mode == 1) begin
                chk("chk_first", got[0], 9'h0AA);
                chk("chk_second", got[1], 9'h155);
                chk("chk_row1_start", got[W-2], 9'h155);
            end
            if (mode == 2) begin
                foreach (got[k]) if (got[k] != 0) nz++;
                chk("single_nonzero", nz, 9);
                chk("single_tl57", got[5*(W-2)+7], 9'h001);
                chk("single_tl35", got[3*(W-2)+5], 9'h100);
                chk("single_tl46", got[4*(W-2)+6], 9'h010);
            end
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; pix_vld = 1'b0; pix_in = 1'b0; win_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_win", win, 0);
        chk("reset_win_vld", win_vld, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_pix_rdy", pix_rdy, 1);
`ifdef CNN_WIN_CNT_EN
        chk("reset_win_cnt", win_cnt, 0);
`endif
        rst = 1'b0;
        run_frame(0, 100, 100, 0, -1, 0, 0);
        run_frame(1, 100, 100, 1, -1, 0, 0);
        run_frame(2, 100, 100, 1, -1, 0, 0);
        run_frame(0, 100, 100, 1, 200, 0, 0);
        run_frame(0, 100, 100, 1, -1, 1, 300);
        run_frame(0, 100, 100, 0, -1, 0, 0);
        run_frame(3, 70, 60, 1, -1, 2, 400);
        run_frame(0, 100, 100, 0, -1, 0, 0);
        run_frame(3, 75, 65, 1, -1, 0, 0);
        run_frame(3, 50, 90, 1, -1, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
